// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter: FSM states, id width and destination extraction.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } arb_state_e;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
    localparam int MAX_PKT_W = 256;

    // Caller zero-extends its packet to MAX_PKT_W; the id lives in the top byte of the real width.
    function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt, input int pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin pick: first set request at or after the pointer, wrapping; one-hot grant plus its index.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    logic [IW-1:0] cand;

    always_comb begin
        cand  = '0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_i) + i >= N) ? IW'(int'(ptr_i) + i - N) : IW'(int'(ptr_i) + i);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter: IDLE picks a driver round-robin, POP dequeues its head, PUSH delivers it to the target(s).
// Define BUS_ARB_DROP_CNT_EN to add the saturating drop_cnt output counting packets with no valid target.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic                            bus_busy
`ifdef BUS_ARB_DROP_CNT_EN
    ,
    output logic [15:0]                     drop_cnt
`endif
);

    localparam int IW = $clog2(drvrs);

    arb_state_e                   state_q;
    logic [IW-1:0]                rr_ptr_q;
    logic [IW-1:0]                gnt_idx_q;
    logic [drvrs-1:0]             pop_q;
    logic [drvrs-1:0]             push_q;
    logic [drvrs-1:0][pckg_sz-1:0] d_push_q;
    logic                         bus_busy_q;

    logic [drvrs-1:0]   gnt_oh_d;
    logic [IW-1:0]      gnt_idx_d;
    logic               gnt_vld_d;
    logic [IW-1:0]      ptr_nxt_d;
    logic [pckg_sz-1:0] pkt_d;
    logic [ID_W-1:0]    dest_d;
    logic [drvrs-1:0]   tgt_mask_d;

    rr_grant #(
        .N  (drvrs),
        .IW (IW)
    ) u_grant (
        .req_i (pndng),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt_oh_d),
        .idx_o (gnt_idx_d),
        .vld_o (gnt_vld_d)
    );

    assign ptr_nxt_d = (int'(gnt_idx_d) == drvrs - 1) ? '0 : gnt_idx_d + 1'b1;

    // The granted FIFO head is stable throughout POP; it is sampled on the edge that leaves POP.
    assign pkt_d  = D_pop[gnt_idx_q];
    assign dest_d = get_dest(MAX_PKT_W'(pkt_d), pckg_sz);

    always_comb begin
        tgt_mask_d = '0;
        if (32'(dest_d) < drvrs) begin
            if (dest_d[IW-1:0] != gnt_idx_q) begin
                tgt_mask_d[dest_d[IW-1:0]] = 1'b1;
            end
        end else if (dest_d == broadcast) begin
            tgt_mask_d            = '1;
            tgt_mask_d[gnt_idx_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            d_push_q   <= '0;
            bus_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        state_q    <= POP;
                        pop_q      <= gnt_oh_d;
                        gnt_idx_q  <= gnt_idx_d;
                        rr_ptr_q   <= ptr_nxt_d;
                        bus_busy_q <= 1'b1;
                    end
                end
                POP: begin
                    state_q <= PUSH;
                    pop_q   <= '0;
                    push_q  <= tgt_mask_d;
                    for (int i = 0; i < drvrs; i++) begin
                        if (tgt_mask_d[i]) begin
                            d_push_q[i] <= pkt_d;
                        end
                    end
                end
                PUSH: begin
                    state_q    <= IDLE;
                    push_q     <= '0;
                    bus_busy_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    pop_q      <= '0;
                    push_q     <= '0;
                    bus_busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (state_q == POP && tgt_mask_d == '0 && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign bus_busy = bus_busy_q;

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter drvrs, default 4, number of bus drivers/receivers (2..16).
REQ-002 SHALL have parameter pckg_sz, default 16, packet width in bits (>=16).
REQ-003 SHALL have parameter broadcast, default 8'hFF, destination id meaning "all receivers".
REQ-004 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pndng  input  drvrs  per-driver FIFO non-empty flag.
REQ-007 SHALL have port D_pop  input  drvrs x pckg_sz  per-driver FIFO head data.
REQ-008 SHALL have port pop  output  drvrs  per-driver one-cycle dequeue strobe.
REQ-009 SHALL have port push  output  drvrs  per-receiver one-cycle enqueue strobe.
REQ-010 SHALL have port D_push  output  drvrs x pckg_sz  per-receiver packet data.
REQ-011 SHALL have port bus_busy  output  1  high while a transfer is in progress.

Function
REQ-012 Packet destination id SHALL be D_pop[pckg_sz-1 -: 8]; remaining bits are payload, forwarded unmodified.
REQ-013 FSM states SHALL be IDLE, POP, PUSH; all outputs registered.
REQ-014 IDLE: if any pndng bit set in cycle N, SHALL grant the first set bit at or after rr pointer (wrapping), enter POP in N+1.
REQ-015 POP: pop[g]=1 for exactly one cycle, all other pop bits 0; D_pop[g] captured at end of that cycle.
REQ-016 PUSH (cycle N+2): push set for target mask, D_push of every targeted receiver = captured packet; return to IDLE in N+3.
REQ-017 Target mask: dest<drvrs and dest!=g -> one-hot dest; dest==broadcast -> all bits except g; otherwise -> empty (packet dropped, no push).
REQ-018 rr pointer SHALL become (g+1) mod drvrs when entering POP; no grant leaves pointer unchanged.
REQ-019 pndng changes during POP/PUSH SHALL be ignored until next IDLE; max throughput one packet per 3 cycles.
REQ-020 pop and push SHALL never assert in the same cycle; bus_busy=1 in POP and PUSH only.
REQ-021 D_push lanes not targeted SHALL hold their previous value.

Reset
REQ-022 reset=0 at a rising edge SHALL force IDLE, pop=0, push=0, D_push=0, bus_busy=0, rr pointer=0.
REQ-023 Reset during POP or PUSH SHALL abort the transfer; the captured packet is discarded, no push issued.

Configuration
REQ-024 With BUS_ARB_DROP_CNT_EN defined: extra output drop_cnt (16 bits) SHALL increment on every dropped packet (REQ-017), saturate at 16'hFFFF, clear on reset.
REQ-025 Without BUS_ARB_DROP_CNT_EN: no drop_cnt port, no counter logic; drop behaviour otherwise identical.

Structure
REQ-026 Package bus_arb_pkg SHALL hold the state enum, ID_W=8, default broadcast id, and a dest-extract function.
REQ-027 Sub-module rr_grant SHALL implement the round-robin pick (request vector, pointer -> one-hot grant + index).

Verification (drvrs=4, pckg_sz=16)
REQ-028 Driver 1 pndng, D_pop=16'h02AB -> pop[1] at N+1, push=4'b0100 with D_push[2]=16'h02AB at N+2, pointer=2.
REQ-029 All four pndng held high -> grant order 0,1,2,3,0 on consecutive transfers, one every 3 cycles.
REQ-030 Driver 0 sends 16'hFF55 -> push=4'b1110, D_push[1..3]=16'hFF55, push[0]=0.
REQ-031 Driver 2 sends 16'h0711 (invalid) and 16'h0233 (self) -> pop asserted each time, push never, drop_cnt=2 when macro defined.
REQ-032 reset=0 in the POP cycle of a transfer -> next cycle IDLE, no push ever, pointer=0, bus_busy=0.
